// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the RISC-TOY pipeline/custom IP and the hazard controller.
// The master side is the pipeline/IP; the slave side is the controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ra_ID;
  logic [4:0]       rb_ID;
  logic             use_ra_ID;
  logic             use_rb_ID;
  logic [4:0]       rd_EX;
  logic             MemRead_EX;
  logic             ip_op_EX;
  logic             branch_taken_EX;
  logic             ip_done;
  logic             PCWrite;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Bubble;
  logic             EXMEM_Bubble;
  logic             ip_start;
  logic             ip_abort;
  logic             ip_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ra_ID, rb_ID, use_ra_ID, use_rb_ID, rd_EX, MemRead_EX,
           ip_op_EX, branch_taken_EX, ip_done,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Bubble,
           ip_start, ip_abort, ip_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  ra_ID, rb_ID, use_ra_ID, use_rb_ID, rd_EX, MemRead_EX,
           ip_op_EX, branch_taken_EX, ip_done,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Bubble,
           ip_start, ip_abort, ip_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and the
// custom-IP start/done/abort handshake, plus saturating stall/flush counters.
module hazard_ctrl #(
  parameter int IP_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input logic           CLK,
  input logic           RST,
  hazard_ctrl_if.slave  bus
);
  localparam int WAIT_W = (IP_TIMEOUT > 2) ? $clog2(IP_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE, IP_WAIT} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  flush_q;

  logic load_use;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble;
  logic start, abort;

  // A zero destination never hazards: r0 is hard-wired and never written.
  assign load_use = bus.MemRead_EX && (bus.rd_EX != 5'd0) &&
                    ((bus.use_ra_ID && (bus.ra_ID == bus.rd_EX)) ||
                     (bus.use_rb_ID && (bus.rb_ID == bus.rd_EX)));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (bus.ip_op_EX) begin
            start        = 1'b1;
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
          end else if (bus.branch_taken_EX) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        IP_WAIT: begin
          // On done the IP result flows into MEM; on timeout it is squashed.
          if (bus.ip_done) begin
            exmem_bubble = 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            abort        = 1'b1;
            exmem_bubble = 1'b1;
          end else begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ip_op_EX) begin
            state    <= IP_WAIT;
            wait_cnt <= '0;
          end
        end
        IP_WAIT: begin
          if (bus.ip_done) begin
            state <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= IDLE;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      if (!pc_write && (stall_q != CNT_MAX))
        stall_q <= stall_q + CNT_W'(1);
      if (ifid_flush && (flush_q != CNT_MAX))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.PCWrite      = pc_write;
  assign bus.IFID_Write   = ifid_write;
  assign bus.IFID_Flush   = ifid_flush;
  assign bus.IDEX_Bubble  = idex_bubble;
  assign bus.EXMEM_Bubble = exmem_bubble;
  assign bus.ip_start     = start;
  assign bus.ip_abort     = abort;
  assign bus.ip_err       = err_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected per-cycle outputs
// from a behavioural model, a monitor pops and compares them on the falling edge.
module tb_hazard_ctrl;
  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();

  hazard_ctrl #(.IP_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (hif)
  );

  typedef struct {
    logic [6:0] ctl;
    logic       err;
    int         sc;
    int         fc;
    bit         full;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: "busy" means an IP op is outstanding, "waited" counts wait cycles.
  bit busy = 0;
  int waited = 0;
  int stalls = 0;
  int flushes = 0;
  bit err = 0;
  int cyc = 0;

  task automatic step(input bit r, input logic [4:0] ra, input logic [4:0] rb,
                      input bit ua, input bit ub, input logic [4:0] rd,
                      input bit mr, input bit ip, input bit br, input bit dn);
    exp_t e;
    bit pc, ifw, fl, idb, exb, st, ab, hz;
    @(posedge clk);
    #1;
    rst = r;
    hif.ra_ID = ra;  hif.rb_ID = rb;  hif.use_ra_ID = ua;  hif.use_rb_ID = ub;
    hif.rd_EX = rd;  hif.MemRead_EX = mr;  hif.ip_op_EX = ip;
    hif.branch_taken_EX = br;  hif.ip_done = dn;
    pc = 1; ifw = 1; fl = 0; idb = 0; exb = 0; st = 0; ab = 0;
    e.err = err; e.sc = stalls; e.fc = flushes; e.full = !r; e.id = cyc;
    hz = mr && (rd != 0) && ((ua && ra == rd) || (ub && rb == rd));
    if (r) begin
      busy = 0; waited = 0; stalls = 0; flushes = 0; err = 0;
    end else begin
      if (!busy) begin
        if (ip) begin
          st = 1; pc = 0; ifw = 0; idb = 1; exb = 1; busy = 1; waited = 0;
        end else if (br) begin
          fl = 1; idb = 1;
          if (flushes < CMAX) flushes++;
        end else if (hz) begin
          pc = 0; ifw = 0; idb = 1;
        end
      end else begin
        if (dn) begin
          busy = 0;
        end else if (waited == TO - 1) begin
          ab = 1; exb = 1; err = 1; busy = 0;
        end else begin
          pc = 0; ifw = 0; idb = 1; exb = 1; waited++;
        end
      end
      if (!pc && stalls < CMAX) stalls++;
    end
    e.ctl = {pc, ifw, fl, idb, exb, st, ab};
    sb.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops one expectation per cycle once the DUT outputs have settled.
  initial begin
    exp_t m;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        m = sb.pop_front();
        act = {hif.PCWrite, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Bubble,
               hif.EXMEM_Bubble, hif.ip_start, hif.ip_abort};
        n_cmp++;
        if (act !== m.ctl) begin
          n_bad++;
          $display("FAIL ctl cyc=%0d got=%b want=%b (PCW,IFW,FL,IDB,EXB,ST,AB)",
                   m.id, act, m.ctl);
        end
        if (m.full) begin
          n_cmp++;
          if (hif.ip_err !== m.err || hif.stall_cnt !== CW'(m.sc) ||
              hif.flush_cnt !== CW'(m.fc)) begin
            n_bad++;
            $display("FAIL state cyc=%0d got err=%b stall=%0d flush=%0d want err=%b stall=%0d flush=%0d",
                     m.id, hif.ip_err, hif.stall_cnt, hif.flush_cnt, m.err, m.sc, m.fc);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    hif.ra_ID = 0; hif.rb_ID = 0; hif.use_ra_ID = 0; hif.use_rb_ID = 0;
    hif.rd_EX = 0; hif.MemRead_EX = 0; hif.ip_op_EX = 0;
    hif.branch_taken_EX = 0; hif.ip_done = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Load-use on ra, then the same with rd_EX = 0.
    step(0, 3, 1, 1, 1, 3, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    step(0, 2, 5, 0, 1, 5, 1, 0, 0, 0);
    step(0, 5, 2, 0, 1, 5, 1, 0, 0, 0);
    // Taken branch masks a load-use hazard.
    step(0, 3, 1, 1, 1, 3, 1, 0, 1, 0);
    idle(1);
    // 4-cycle IP op; a done coinciding with start is ignored.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(2);
    // Timeout: ip_done never arrives.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < TO; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);
    // Reset on the 2nd wait cycle drops the op silently.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(TO + 2);
    // Back-to-back load-use stalls push stall_cnt into saturation.
    for (int i = 0; i < 20; i++) step(0, 7, 0, 1, 0, 7, 1, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Randomized traffic with small register numbers to make hazards frequent.
    for (int i = 0; i < 1500; i++) begin
      bit r, ip, dn;
      r  = ($urandom_range(0, 199) == 0);
      ip = busy ? 1'b1 : ($urandom_range(0, 9) == 0);
      dn = ($urandom_range(0, 5) == 0);
      step(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ip, 1'($urandom_range(0, 4) == 0), dn);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
